// File: rtl/led_hex_pkg.sv
// Shared constants and helpers for the led_hex_scan multiplexed 7-segment driver.
package led_hex_pkg;

  // Active-high gfedcba patterns for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_hex_pwm.sv
// Brightness window for one digit slot: anode enabled for
// BLANK_CYCLES <= p < BLANK_CYCLES + ((PRESCALE-BLANK_CYCLES)*(brightness+1))>>4.
module led_hex_pwm
  import led_hex_pkg::*;
#(
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int PW           = cnt_width(PRESCALE)
) (
  input  logic [PW-1:0] p,
  input  logic [3:0]    brightness,
  output logic          an_en
);

  // Four extra bits hold W*16 without overflow; one more keeps the sum safe
  localparam int EW = PW + 5;
  localparam int W  = PRESCALE - BLANK_CYCLES;

  logic [EW-1:0] prod;
  logic [EW-1:0] on_time;
  logic [EW-1:0] p_ext;

  always_comb begin
    prod    = EW'(W) * EW'({1'b0, brightness} + 5'd1);
    on_time = prod >> 4;
    p_ext   = EW'(p);
    an_en   = (p_ext >= EW'(BLANK_CYCLES)) && (p_ext < EW'(BLANK_CYCLES) + on_time);
  end

endmodule

// File: rtl/led_hex_scan.sv
// N-digit multiplexed hex display driver with blanking, PWM and frame-synchronised loads.
// Optional macro LED_HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module led_hex_scan
  import led_hex_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic [3:0]            brightness,
  output logic [7:0]            led_c,
  output logic [DIGITS-1:0]     led_a,
  output logic                  frame
);

  localparam int PW = cnt_width(PRESCALE);
  localparam int DW = cnt_width(DIGITS);
  localparam logic [PW-1:0]     P_LAST  = PW'(PRESCALE - 1);
  localparam logic [DW-1:0]     D_LAST  = DW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]         p;
  logic [DW-1:0]         d;
  logic                  slot_end;
  logic                  frame_end;

  logic [4*DIGITS-1:0]   pend_num;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pending;
  logic [4*DIGITS-1:0]   disp_num;
  logic [DIGITS-1:0]     disp_dp;

  logic [3:0]            nib;
  logic                  dig_dp;
  logic                  blank;
  logic                  an_en;
  logic [7:0]            seg_hi;
  logic [DIGITS-1:0]     an_hi;

  assign slot_end  = (p == P_LAST);
  assign frame_end = slot_end && (d == D_LAST);

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample the pre-edge values and simulation matches the synthesised netlist.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      p <= '0;
      d <= '0;
    end else if (slot_end) begin
      p <= '0;
      d <= (d == D_LAST) ? '0 : d + DW'(1);
    end else begin
      p <= p + PW'(1);
    end
  end

  // NOTE: the buffers are a handful of flops, not a RAM, so they take the
  // reset like any other register and a reset discards any pending value.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      pend_num <= '0;
      pend_dp  <= '0;
      pending  <= 1'b0;
      disp_num <= '0;
      disp_dp  <= '0;
    end else begin
      if (frame_end && pending) begin
        disp_num <= pend_num;
        disp_dp  <= pend_dp;
        pending  <= 1'b0;
      end
      // A load in the boundary cycle lands in pending after the old value moved on
      if (load) begin
        pend_num <= number;
        pend_dp  <= dp;
        pending  <= 1'b1;
      end
    end
  end

  led_hex_pwm #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES),
    .PW           (PW)
  ) u_pwm (
    .p          (p),
    .brightness (brightness),
    .an_en      (an_en)
  );

  // NOTE: each comb output gets a default before the loop so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    nib    = '0;
    dig_dp = 1'b0;
    an_hi  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (DW'(i) == d) begin
        nib    = disp_num[4*(DIGITS-1-i) +: 4];
        dig_dp = disp_dp[DIGITS-1-i];
      end
      // Digit 0 drives the top anode bit, matching the number/dp ordering
      an_hi[DIGITS-1-i] = an_en && (DW'(i) == d);
    end
  end

`ifdef LED_HEX_LEADING_ZERO_BLANK_EN
  logic zero_run;

  always_comb begin
    blank    = 1'b0;
    zero_run = 1'b1;
    for (int i = 0; i < DIGITS - 1; i++) begin
      zero_run = zero_run && (disp_num[4*(DIGITS-1-i) +: 4] == 4'h0);
      if (DW'(i) == d) blank = zero_run;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_hi = {dig_dp, blank ? 7'h00 : hex_to_seg(nib)};

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      led_c <= SEG_OFF;
      led_a <= AN_OFF;
      frame <= 1'b0;
    end else begin
      led_c <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      led_a <= AN_ACTIVE_LOW ? ~an_hi : an_hi;
      frame <= frame_end;
    end
  end

endmodule

// File: tb/tb_led_hex_scan.sv
// Directed bench for led_hex_scan (4 digits, 32-cycle slots, 4-cycle blank); a second
// active-high instance is cross-checked against the active-low one every cycle.
module tb_led_hex_scan;

  localparam int DIGITS    = 4;
  localparam int PRESCALE  = 32;
  localparam int BLANK     = 4;
  localparam int FRAME_LEN = DIGITS * PRESCALE;

  logic        sclk = 1'b0;
  logic        reset;
  logic [15:0] number;
  logic [3:0]  dp;
  logic        load;
  logic [3:0]  brightness;
  logic [7:0]  led_c, led_c_hi;
  logic [3:0]  led_a, led_a_hi;
  logic        frame, frame_hi;

  int compared   = 0;
  int mismatched = 0;

  always #5 sclk = ~sclk;

  led_hex_scan #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .sclk(sclk), .reset(reset), .number(number), .dp(dp), .load(load),
    .brightness(brightness), .led_c(led_c), .led_a(led_a), .frame(frame)
  );

  led_hex_scan #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .sclk(sclk), .reset(reset), .number(number), .dp(dp), .load(load),
    .brightness(brightness), .led_c(led_c_hi), .led_a(led_a_hi), .frame(frame_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] num, input logic [3:0] dpv);
    number = num;
    dp     = dpv;
    load   = 1'b1;
    @(negedge sclk);
    load   = 1'b0;
  endtask

  // Advance to the next frame pulse; exp_k > 0 also checks how many cycles it took
  task automatic wait_frame(input string tag, input int budget, input int exp_k);
    int k = 0;
    bit seen = 1'b0;
    while (k < budget && !seen) begin
      @(negedge sclk);
      k++;
      if (frame === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (exp_k > 0 && seen) check({tag, "_period"}, k, exp_k);
  endtask

  // Observe one whole frame, starting on the negedge that showed the frame pulse
  task automatic scan_frame(input string tag, input logic [31:0] exp_seg, input int exp_on);
    logic [7:0] seg_seen [DIGITS];
    int on_cnt [DIGITS];
    int first_on [DIGITS];
    int seg_var = 0, stray = 0, pol_bad = 0, early = 0;
    logic [3:0] act;
    for (int i = 0; i < DIGITS; i++) begin
      seg_seen[i] = '0;
      on_cnt[i]   = 0;
      first_on[i] = -1;
    end
    for (int k = 1; k <= FRAME_LEN; k++) begin
      int dig, pos;
      @(negedge sclk);
      dig = (k - 1) / PRESCALE;
      pos = (k - 1) % PRESCALE;
      if (pos == 0) seg_seen[dig] = led_c;
      else if (led_c !== seg_seen[dig]) seg_var++;
      act = ~led_a;
      for (int a = 0; a < DIGITS; a++) begin
        if (act[a] === 1'b1) begin
          if (a == DIGITS - 1 - dig) begin
            on_cnt[dig]++;
            if (first_on[dig] < 0) first_on[dig] = pos;
          end else begin
            stray++;
          end
        end
      end
      if (led_c_hi !== ~led_c || led_a_hi !== ~led_a || frame_hi !== frame) pol_bad++;
      if (k < FRAME_LEN && frame !== 1'b0) early++;
    end
    for (int i = 0; i < DIGITS; i++) begin
      check($sformatf("%s_seg%0d", tag, i), 32'(seg_seen[i]), 32'(exp_seg[31-8*i -: 8]));
      check($sformatf("%s_on%0d", tag, i), on_cnt[i], exp_on);
      check($sformatf("%s_start%0d", tag, i), first_on[i], BLANK);
    end
    check({tag, "_seg_steady"}, seg_var, 0);
    check({tag, "_stray_anode"}, stray, 0);
    check({tag, "_polarity"}, pol_bad, 0);
    check({tag, "_frame_early"}, early, 0);
    check({tag, "_frame_end"}, 32'(frame), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    number     = '0;
    dp         = '0;
    load       = 1'b0;
    brightness = 4'd15;
    repeat (3) @(negedge sclk);
    check("rst_led_a", 32'(led_a), 32'hF);
    check("rst_led_c", 32'(led_c), 32'hFF);
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_led_a_hi", 32'(led_a_hi), 32'h0);
    check("rst_led_c_hi", 32'(led_c_hi), 32'h00);
    reset = 1'b0;

    wait_frame("first", 200, FRAME_LEN);

    // Basic load: value appears the frame after the boundary that follows it
    do_load(16'h1234, 4'b0000);
    wait_frame("load1", 200, FRAME_LEN - 1);
    scan_frame("n1234", 32'hF9A4B099, 28);

    brightness = 4'd0;
    scan_frame("br0", 32'hF9A4B099, 1);
    brightness = 4'd7;
    scan_frame("br7", 32'hF9A4B099, 14);
    brightness = 4'd15;

    do_load(16'h1234, 4'b1010);
    wait_frame("dp", 200, FRAME_LEN - 1);
    scan_frame("dp", 32'h79A43099, 28);

    // Tearing: two loads inside one frame, only the last reaches the display
    fork
      scan_frame("tear_cur", 32'h79A43099, 28);
      begin
        repeat (40) @(negedge sclk);
        do_load(16'hAAAA, 4'b0000);
        repeat (49) @(negedge sclk);
        do_load(16'h5555, 4'b0000);
      end
    join
    scan_frame("tear_next", 32'h92929292, 28);
    scan_frame("tear_hold", 32'h92929292, 28);

    // Load in the boundary cycle: display takes the older pending value
    repeat (5) @(negedge sclk);
    do_load(16'h1111, 4'b0000);
    repeat (121) @(negedge sclk);
    number = 16'h2222;
    load   = 1'b1;
    @(negedge sclk);
    check("bnd_frame", 32'(frame), 32'd1);
    load   = 1'b0;
    scan_frame("bnd_1111", 32'hF9F9F9F9, 28);
    scan_frame("bnd_2222", 32'hA4A4A4A4, 28);

    // Reset in the middle of digit 2 with a value pending
    do_load(16'h7777, 4'b0000);
    repeat (73) @(negedge sclk);
    check("pre_rst_an", 32'(led_a), 32'hD);
    reset = 1'b1;
    #1;
    check("mid_rst_led_a", 32'(led_a), 32'hF);
    check("mid_rst_led_c", 32'(led_c), 32'hFF);
    check("mid_rst_frame", 32'(frame), 32'h0);
    @(negedge sclk);
    reset = 1'b0;
    @(negedge sclk);
    check("post_rst_blank_a", 32'(led_a), 32'hF);
    check("post_rst_blank_c", 32'(led_c), 32'hC0);
    repeat (4) @(negedge sclk);
    check("post_rst_on_a", 32'(led_a), 32'h7);
    check("post_rst_on_c", 32'(led_c), 32'hC0);
    wait_frame("post_rst", 200, FRAME_LEN - 5);
    scan_frame("rst_zero", 32'hC0C0C0C0, 28);

    do_load(16'h00A0, 4'b0000);
    wait_frame("lz", 200, FRAME_LEN - 1);
`ifdef LED_HEX_LEADING_ZERO_BLANK_EN
    scan_frame("lz", 32'hFFFF88C0, 28);
`else
    scan_frame("lz", 32'hC0C088C0, 28);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
